fifo_reader: RTL and testbench

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_pkg.sv | 14 +
 rtl/fifo_skid2.sv | 76 +++++++
 rtl/fifo_reader.sv | 88 ++++++++
 tb/tb_fifo_reader.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO drain path.
// Skid buffer states mirror occupancy directly.
package fifo_pkg;

  localparam int DEF_FIFO_WIDTH = 16;
  localparam int DEF_FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

endpackage

// File: rtl/fifo_skid2.sv
// Two-entry skid buffer between FIFO read data and the stream port.
// Head is always the oldest word; second promotes on pop.
module fifo_skid2
  import fifo_pkg::*;
#(
  parameter int W = DEF_FIFO_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output skid_state_t  occ,
  output logic [W-1:0] head,
  output logic [W-1:0] second
);

  skid_state_t  state_q, state_d;
  logic [W-1:0] d0_q, d0_d;
  logic [W-1:0] d1_q, d1_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      d0_q    <= '0;
      d1_q    <= '0;
    end else begin
      state_q <= state_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    d0_d    = d0_q;
    d1_d    = d1_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          d0_d    = push_data;
        end
      end
      ONE: begin
        if (push && pop) begin
          d0_d = push_data;
        end else if (push) begin
          state_d = TWO;
          d1_d    = push_data;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_d = ONE;
          d0_d    = d1_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // The issue rule upstream must never let a word land while full.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && state_q == TWO));
    end
  end

  assign occ    = state_q;
  assign head   = d0_q;
  assign second = d1_q;

endmodule

// File: rtl/fifo_reader.sv
// Drains a FIFO with one-cycle read latency into a valid/ready stream.
// Issue is throttled so buffered plus in-flight words never exceed two.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  drain_en,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  drained_cnt,
  output logic                  underflow_seen
);

  skid_state_t           occ;
  logic [FIFO_WIDTH-1:0] skid_head;
  logic [FIFO_WIDTH-1:0] skid_second;
  logic                  inflight;
  logic [2:0]            load;
  logic                  pop;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  uflow_q;
  logic [FIFO_WIDTH-1:0] promote_q;
  logic                  promote_chk_q;

  assign load = {1'b0, occ} + {2'b00, inflight};

  assign fifo_rd_en = !rst && drain_en &&
                      !fifo_empty && (load < 3'd2);

  assign m_valid = !rst && (occ != EMPTY);
  assign m_data  = rst ? '0 : skid_head;
  assign pop     = m_valid && m_ready;

  assign drained_cnt    = rst ? '0 : cnt_q;
  assign underflow_seen = !rst && uflow_q;

  fifo_skid2 #(
    .W (FIFO_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (fifo_data_out),
    .pop       (pop),
    .occ       (occ),
    .head      (skid_head),
    .second    (skid_second)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 1'b0;
      cnt_q    <= '0;
      uflow_q  <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      if (pop) begin
        cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
      if (fifo_underflow) begin
        uflow_q <= 1'b1;
      end
    end
  end

  // A pop from TWO must promote the second entry to head.
  always_ff @(posedge clk) begin
    if (rst) begin
      promote_chk_q <= 1'b0;
    end else begin
      promote_chk_q <= pop && (occ == TWO);
      promote_q     <= skid_second;
      if (promote_chk_q) begin
        assert (skid_head == promote_q);
      end
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// Randomized and directed bench for fifo_reader against a queue model.
// Source FIFO and expected output stream are both plain queues.
module tb_fifo_reader;

  localparam int W  = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          drain_en;
  logic          fifo_empty;
  logic [W-1:0]  fifo_data_out;
  logic          fifo_underflow;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready;
  logic [W-1:0]  m_data;
  logic [CW-1:0] drained_cnt;
  logic          underflow_seen;

  fifo_reader #(
    .FIFO_WIDTH (W),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .drain_en       (drain_en),
    .fifo_empty     (fifo_empty),
    .fifo_data_out  (fifo_data_out),
    .fifo_underflow (fifo_underflow),
    .fifo_rd_en     (fifo_rd_en),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .drained_cnt    (drained_cnt),
    .underflow_seen (underflow_seen)
  );

  always #5 clk = ~clk;

  logic [W-1:0] src_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] infl_word;
  bit           infl_m;
  int           exp_cnt;
  bit           exp_useen;
  int           delivered;
  int           tests;
  int           fails;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // One clock: check outputs, then advance the model.
  task automatic cycle();
    bit exp_rd;
    bit exp_v;
    bit exp_xfer;
    fifo_empty = (src_q.size() == 0);
    #1;
    exp_rd = !rst && drain_en && !fifo_empty &&
             (exp_q.size() + int'(infl_m) < 2);
    exp_v  = !rst && (exp_q.size() != 0);
    check("rd_en", 32'(fifo_rd_en), 32'(exp_rd));
    check("m_valid", 32'(m_valid), 32'(exp_v));
    if (exp_v)
      check("m_data", 32'(m_data), 32'(exp_q[0]));
    else if (rst)
      check("rst_data", 32'(m_data), 32'h0);
    check("cnt", 32'(drained_cnt),
          rst ? 32'h0 : 32'(exp_cnt % 16));
    check("uflow", 32'(underflow_seen),
          rst ? 32'h0 : 32'(exp_useen));
    exp_xfer = exp_v && m_ready;
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
      infl_m    = 1'b0;
      exp_cnt   = 0;
      exp_useen = 1'b0;
    end else begin
      if (exp_xfer) begin
        void'(exp_q.pop_front());
        exp_cnt++;
        delivered++;
      end
      if (infl_m) exp_q.push_back(infl_word);
      infl_m = exp_rd;
      if (exp_rd) infl_word = src_q.pop_front();
      if (fifo_underflow) exp_useen = 1'b1;
    end
    fifo_data_out = exp_rd ? infl_word : W'($urandom);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    drain_en       = 1'b1;
    m_ready        = 1'b0;
    fifo_underflow = 1'b0;
    src_q.delete();
    src_q.push_back(16'h1234);
    repeat (2) cycle();
    src_q.delete();
    rst       = 1'b0;
    drain_en  = 1'b0;
    delivered = 0;
  endtask

  task automatic run_until(input int n, input int bound);
    int k = 0;
    while (delivered < n && k < bound) begin
      cycle();
      k++;
    end
    check("done", 32'(delivered), 32'(n));
  endtask

  initial begin
    int first;
    tests          = 0;
    fails          = 0;
    rst            = 1'b1;
    drain_en       = 1'b0;
    m_ready        = 1'b0;
    fifo_empty     = 1'b1;
    fifo_underflow = 1'b0;
    fifo_data_out  = '0;
    infl_m         = 1'b0;
    exp_cnt        = 0;
    exp_useen      = 1'b0;
    delivered      = 0;
    @(posedge clk);
    #1;
    @(negedge clk);
    do_reset();

    // Streaming 1..8 with fill-latency measurement.
    for (int i = 1; i <= 8; i++) src_q.push_back(W'(i));
    drain_en = 1'b1;
    m_ready  = 1'b1;
    first    = -1;
    for (int k = 0; k < 60 && delivered < 8; k++) begin
      if (m_valid && first < 0) first = k;
      cycle();
    end
    check("fill_lat", 32'(first), 32'd2);
    check("stream_cnt", 32'(drained_cnt), 32'd8);

    // Backpressure mid-stream, then release.
    do_reset();
    for (int i = 0; i < 10; i++) src_q.push_back(W'(16'h100 + i));
    drain_en = 1'b1;
    m_ready  = 1'b1;
    repeat (4) cycle();
    m_ready = 1'b0;
    repeat (5) cycle();
    check("bp_hold", 32'(m_valid), 32'd1);
    m_ready = 1'b1;
    run_until(10, 80);

    // Single-cycle drain pulse.
    do_reset();
    src_q.push_back(16'hA5A5);
    drain_en = 1'b1;
    m_ready  = 1'b1;
    cycle();
    drain_en = 1'b0;
    repeat (6) cycle();
    check("pulse_n", 32'(delivered), 32'd1);
    check("pulse_idle", 32'(m_valid), 32'd0);

    // Counter wrap after 17 transfers.
    do_reset();
    for (int i = 0; i < 17; i++) src_q.push_back(W'($urandom));
    drain_en = 1'b1;
    m_ready  = 1'b1;
    run_until(17, 120);
    check("wrap", 32'(drained_cnt), 32'd1);

    // Sticky underflow until reset.
    drain_en       = 1'b0;
    fifo_underflow = 1'b1;
    cycle();
    fifo_underflow = 1'b0;
    repeat (4) cycle();
    check("uflow_sticky", 32'(underflow_seen), 32'd1);
    do_reset();
    check("uflow_clr", 32'(underflow_seen), 32'd0);

    // Reset while the skid buffer is full.
    for (int i = 0; i < 8; i++) src_q.push_back(W'(16'h200 + i));
    drain_en = 1'b1;
    m_ready  = 1'b1;
    repeat (3) cycle();
    m_ready = 1'b0;
    repeat (4) cycle();
    check("pre_rst_cnt", 32'(drained_cnt), 32'(exp_cnt % 16));
    rst = 1'b1;
    repeat (2) cycle();
    check("mid_rst_v", 32'(m_valid), 32'd0);
    check("mid_rst_c", 32'(drained_cnt), 32'd0);
    check("mid_rst_rd", 32'(fifo_rd_en), 32'd0);
    rst       = 1'b0;
    delivered = 0;

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      drain_en       = ($urandom_range(0, 3) != 0);
      m_ready        = ($urandom_range(0, 2) != 0);
      fifo_underflow = ($urandom_range(0, 99) == 0);
      if (src_q.size() < 3 && $urandom_range(0, 1) == 1)
        src_q.push_back(W'($urandom));
      cycle();
    end
    drain_en       = 1'b0;
    m_ready        = 1'b1;
    fifo_underflow = 1'b0;
    repeat (4) cycle();
    check("final_idle", 32'(m_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
